imem_boot_loader: RTL and testbench

Program loader and fetch gate for the instruction memory of the MIPS pipeline. Accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit words and writes them sequentially into instruction memory from word 0. Holds the pipeline stalled from reset until a load completes, then releases it. A later `start` pulse reloads the program at run time.

---
 rtl/imem_boot_loader.sv | 114 +++++++++++
 tb/tb_imem_boot_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: packs a byte stream big-endian into words,
// writes them from word 0 upward and holds the CPU stalled until the load finishes.
module imem_boot_loader #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              err,
  output logic [AWIDTH:0]   word_cnt
);

  localparam int LANES = DWIDTH / 8;
  localparam logic [AWIDTH:0] LAST_WORD = (AWIDTH+1)'((1 << AWIDTH) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [DWIDTH-1:0] pack;
  logic [DWIDTH-1:0] next_word;
  logic              xfer;

  assign xfer = ld_valid && ld_ready;

  // Lanes below the current byte are kept, the current lane takes the new
  // byte and lanes above it read as zero, so a short last word comes out padded.
  always_comb begin
    next_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l < int'(byte_cnt))
        next_word[DWIDTH-1-8*l -: 8] = pack[DWIDTH-1-8*l -: 8];
      else if (l == int'(byte_cnt))
        next_word[DWIDTH-1-8*l -: 8] = ld_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      pack      <= '0;
      ld_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_stall <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state     <= LOAD;
            ld_ready  <= 1'b1;
            cpu_stall <= 1'b1;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            err       <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            pack     <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3 || ld_last) begin
              mem_we    <= 1'b1;
              mem_waddr <= word_cnt[AWIDTH-1:0];
              mem_wdata <= next_word;
              word_cnt  <= word_cnt + 1'b1;
              byte_cnt  <= '0;
            end
            // A final byte mid-word or a full memory both end the load with an error.
            if (ld_last) begin
              if (byte_cnt != 2'd3)
                err <= 1'b1;
              state    <= FLUSH;
              ld_ready <= 1'b0;
            end else if (byte_cnt == 2'd3 && word_cnt == LAST_WORD) begin
              err      <= 1'b1;
              state    <= FLUSH;
              ld_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state     <= RUN;
          cpu_stall <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and random byte streams
// compared against a word-packing model built directly from the stream bytes.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        done;
  logic        err;
  logic [5:0]  word_cnt;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  stim [0:139];

  imem_boot_loader #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_waddr);
      wd.push_back(mem_wdata);
    end
    if (rst_n && done) done_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one load of n bytes from stim[], then compares the writes against the model.
  task automatic applyStimulus(input int n, input bit with_last, input bit gap, input bit do_start);
    int accepted, cyc, c, nw;
    bit timed_out;
    logic [31:0] exp_words [0:31];
    logic        exp_err;
    wa.delete(); wd.delete(); done_seen = 0;
    if (do_start) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checkOutput("ready_after_start", ld_ready, 1);
      checkOutput("stall_in_load", cpu_stall, 1);
      checkOutput("err_cleared", err, 0);
      checkOutput("cnt_cleared", word_cnt, 0);
    end
    accepted = 0; cyc = 0; timed_out = 0;
    forever begin
      if ((with_last && accepted == n) || (accepted > 0 && !ld_ready)) break;
      if (cyc >= 600 || accepted >= 140) begin timed_out = 1; break; end
      ld_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      ld_byte  = stim[accepted];
      ld_last  = with_last && (accepted == n - 1);
      if (ld_valid && ld_ready) accepted++;
      cyc++;
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checkOutput("load_timeout", timed_out, 0);
    checkOutput("flush_we", mem_we, 1);
    checkOutput("flush_stall", cpu_stall, 1);
    checkOutput("flush_ready", ld_ready, 0);
    @(negedge clk);
    checkOutput("run_done", done, 1);
    checkOutput("run_stall", cpu_stall, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("done_count", done_seen, 1);

    c = (n > 128) ? 128 : n;
    nw = (c + 3) / 4;
    for (int j = 0; j < 32; j++) exp_words[j] = '0;
    for (int i = 0; i < c; i++)
      exp_words[i / 4] = exp_words[i / 4] | (32'(stim[i]) << (24 - 8 * (i % 4)));
    exp_err = ((c % 4) != 0) || !(with_last && c == n);
    checkOutput("bytes_consumed", accepted, c);
    checkOutput("write_count", wa.size(), nw);
    for (int j = 0; j < nw && j < wa.size(); j++) begin
      checkOutput($sformatf("waddr[%0d]", j), wa[j], j);
      checkOutput($sformatf("wdata[%0d]", j), wd[j], exp_words[j]);
    end
    checkOutput("word_cnt", word_cnt, nw);
    checkOutput("err", err, exp_err);
  endtask

  initial begin
    int sz;
    #12;
    checkOutput("rst_stall", cpu_stall, 1);
    checkOutput("rst_ready", ld_ready, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_cnt", word_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    ld_valid = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_hold_stall", cpu_stall, 1);
    checkOutput("idle_no_ready", ld_ready, 0);
    checkOutput("idle_no_write", wa.size(), 0);
    ld_valid = 1'b0;

    // Two-word program, back-to-back then with a toggling valid.
    stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
    stim[4] = 8'h01; stim[5] = 8'h09; stim[6] = 8'h50; stim[7] = 8'h20;
    applyStimulus(8, 1, 0, 1);
    if (wd.size() == 2) begin
      checkOutput("two_word_w0", wd[0], 32'h20080005);
      checkOutput("two_word_w1", wd[1], 32'h01095020);
    end else checkOutput("two_word_size", wd.size(), 2);
    applyStimulus(8, 1, 1, 1);

    // Short last word.
    stim[0] = 8'hAA; stim[1] = 8'hBB;
    applyStimulus(2, 1, 0, 1);
    if (wd.size() == 1) checkOutput("short_w0", wd[0], 32'hAABB0000);

    // Reload from RUN, with a redundant start inside LOAD.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("reload_stall", cpu_stall, 1);
    checkOutput("reload_err_clr", err, 0);
    checkOutput("reload_cnt_clr", word_cnt, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("start_in_load_ready", ld_ready, 1);
    checkOutput("start_in_load_cnt", word_cnt, 0);
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    applyStimulus(4, 1, 0, 0);

    // Overflow: 132 bytes, no last.
    for (int i = 0; i < 132; i++) stim[i] = 8'($urandom);
    applyStimulus(132, 0, 0, 1);

    // Random-length streams.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      applyStimulus(n, 1, $urandom_range(0, 1) == 1, 1);
    end

    // Asynchronous reset in the middle of a load.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_byte = 8'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_stall", cpu_stall, 1);
    checkOutput("async_rst_ready", ld_ready, 0);
    checkOutput("async_rst_we", mem_we, 0);
    checkOutput("async_rst_cnt", word_cnt, 0);
    checkOutput("async_rst_waddr", mem_waddr, 0);
    checkOutput("async_rst_wdata", mem_wdata, 0);
    checkOutput("async_rst_err", err, 0);
    checkOutput("async_rst_done", done, 0);
    sz = wa.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_write_after_rst", wa.size(), sz);
    checkOutput("stall_after_rst", cpu_stall, 1);
    ld_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
